// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared constants and the write-back entry type for the
//                8-entry, 8-bit register file and its write-back queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int REG_WORD_LENGTH = 8;
    localparam int REG_ADDR_BITS   = 3;
    localparam int REG_COUNT       = 8;

    typedef struct packed {
        logic [REG_ADDR_BITS-1:0]   addr;
        logic [REG_WORD_LENGTH-1:0] data;
    } wb_entry_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/wb_match.sv
`default_nettype none
// ============================================================================
//  Module      : wb_match
//  Description : Combinational youngest-first address compare over the
//                pending write-back entries; reports a hit and its data.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_match
    import reg_file_pkg::*;
#(
    parameter int WORD_LENGTH = REG_WORD_LENGTH,
    parameter int ADDR_BITS   = REG_ADDR_BITS,
    parameter int DEPTH       = 4
) (
    input  logic [ADDR_BITS-1:0]              rd_addr,
    // Index 0 is the youngest entry, index DEPTH-1 the oldest.
    input  logic [DEPTH-1:0][ADDR_BITS-1:0]   entry_addr,
    input  logic [DEPTH-1:0][WORD_LENGTH-1:0] entry_data,
    input  logic [DEPTH-1:0]                  entry_valid,
    output logic                              hit,
    output logic [WORD_LENGTH-1:0]            hit_data
);

    // Scan oldest to youngest so the youngest matching entry overwrites last.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_valid[i] && (entry_addr[i] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = entry_data[i];
            end
        end
    end

endmodule : wb_match
`default_nettype wire

// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_queue
//  Description : Write-back FIFO in front of the register file write port,
//                with read-coherence (hazard or bypass) on both read ports.
//                Build option: define WB_BYPASS_EN to forward pending data.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_queue
    import reg_file_pkg::*;
#(
    parameter int WORD_LENGTH = REG_WORD_LENGTH,
    parameter int ADDR_BITS   = REG_ADDR_BITS,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_BITS-1:0]         req_addr,
    input  logic [WORD_LENGTH-1:0]       req_data,
    input  logic                         stall,
    output logic                         reg_Write,
    output logic [ADDR_BITS-1:0]         Write_Register,
    output logic [WORD_LENGTH-1:0]       Write_Data,
    input  logic [ADDR_BITS-1:0]         Read_Register_1,
    input  logic [ADDR_BITS-1:0]         Read_Register_2,
    input  logic [WORD_LENGTH-1:0]       rf_Read_Data_1,
    input  logic [WORD_LENGTH-1:0]       rf_Read_Data_2,
    output logic [WORD_LENGTH-1:0]       Read_Data_1,
    output logic [WORD_LENGTH-1:0]       Read_Data_2,
    output logic                         hazard_1,
    output logic                         hazard_2,
    output logic [$clog2(DEPTH):0]       pending,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_BITS-1:0]   r_mem_addr [DEPTH];
    logic [WORD_LENGTH-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic [PTR_W-1:0]       w_last_ptr;

    logic [DEPTH-1:0][ADDR_BITS-1:0]   w_age_addr;
    logic [DEPTH-1:0][WORD_LENGTH-1:0] w_age_data;
    logic [DEPTH-1:0]                  w_age_valid;

    logic                   w_hit_1;
    logic                   w_hit_2;
    logic [WORD_LENGTH-1:0] w_hit_data_1;
    logic [WORD_LENGTH-1:0] w_hit_data_2;

    // Ready depends only on occupancy, never on stall, so no pop-through when full.
    assign req_ready  = (r_count != CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = req_valid && req_ready;
    assign w_pop      = !w_empty && !stall;
    assign w_last_ptr = r_wr_ptr - PTR_W'(1);

    assign reg_Write      = w_pop;
    assign Write_Register = w_empty ? r_mem_addr[w_last_ptr] : r_mem_addr[r_rd_ptr];
    assign Write_Data     = w_empty ? r_mem_data[w_last_ptr] : r_mem_data[r_rd_ptr];
    assign pending        = r_count;
    assign empty          = w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= req_addr;
            r_mem_data[r_wr_ptr] <= req_data;
        end
    end

    // Present the entries ordered by age, youngest at index 0.
    generate
        for (genvar j = 0; j < DEPTH; j++) begin : g_age
            logic [PTR_W-1:0] w_idx;
            assign w_idx          = r_wr_ptr - PTR_W'(j + 1);
            assign w_age_addr[j]  = r_mem_addr[w_idx];
            assign w_age_data[j]  = r_mem_data[w_idx];
            assign w_age_valid[j] = (r_count > CNT_W'(j));
        end
    endgenerate

    wb_match #(
        .WORD_LENGTH (WORD_LENGTH),
        .ADDR_BITS   (ADDR_BITS),
        .DEPTH       (DEPTH)
    ) u_match_1 (
        .rd_addr     (Read_Register_1),
        .entry_addr  (w_age_addr),
        .entry_data  (w_age_data),
        .entry_valid (w_age_valid),
        .hit         (w_hit_1),
        .hit_data    (w_hit_data_1)
    );

    wb_match #(
        .WORD_LENGTH (WORD_LENGTH),
        .ADDR_BITS   (ADDR_BITS),
        .DEPTH       (DEPTH)
    ) u_match_2 (
        .rd_addr     (Read_Register_2),
        .entry_addr  (w_age_addr),
        .entry_data  (w_age_data),
        .entry_valid (w_age_valid),
        .hit         (w_hit_2),
        .hit_data    (w_hit_data_2)
    );

`ifdef WB_BYPASS_EN
    assign Read_Data_1 = w_hit_1 ? w_hit_data_1 : rf_Read_Data_1;
    assign Read_Data_2 = w_hit_2 ? w_hit_data_2 : rf_Read_Data_2;
    assign hazard_1    = 1'b0;
    assign hazard_2    = 1'b0;
`else
    // Without forwarding the consumer must stall while its register is pending.
    logic w_unused_hit_data;
    assign w_unused_hit_data = ^{w_hit_data_1, w_hit_data_2};
    assign Read_Data_1 = rf_Read_Data_1;
    assign Read_Data_2 = rf_Read_Data_2;
    assign hazard_1    = w_hit_1;
    assign hazard_2    = w_hit_2;
`endif

endmodule : reg_wb_queue
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb_queue
//  Description : Self-checking bench for reg_wb_queue: directed scenarios plus
//                random traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_queue;
    import reg_file_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       stall = 1'b0;
    logic       reg_Write;
    logic [2:0] Write_Register;
    logic [7:0] Write_Data;
    logic [2:0] Read_Register_1 = '0;
    logic [2:0] Read_Register_2 = '0;
    logic [7:0] rf_Read_Data_1 = '0;
    logic [7:0] rf_Read_Data_2 = '0;
    logic [7:0] Read_Data_1;
    logic [7:0] Read_Data_2;
    logic       hazard_1;
    logic       hazard_2;
    logic [2:0] pending;
    logic       empty;

    int n_cmp = 0;
    int n_err = 0;

    wb_entry_t exp_q[$];

    always #5 clk = ~clk;

    reg_wb_queue #(
        .WORD_LENGTH (REG_WORD_LENGTH),
        .ADDR_BITS   (REG_ADDR_BITS),
        .DEPTH       (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .stall           (stall),
        .reg_Write       (reg_Write),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data),
        .Read_Register_1 (Read_Register_1),
        .Read_Register_2 (Read_Register_2),
        .rf_Read_Data_1  (rf_Read_Data_1),
        .rf_Read_Data_2  (rf_Read_Data_2),
        .Read_Data_1     (Read_Data_1),
        .Read_Data_2     (Read_Data_2),
        .hazard_1        (hazard_1),
        .hazard_2        (hazard_2),
        .pending         (pending),
        .empty           (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest-first search of the model queue for a read address.
    task automatic lookup(input logic [2:0] ra, output bit hit, output logic [7:0] d);
        hit = 0;
        d   = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].addr == ra) begin
                hit = 1;
                d   = exp_q[i].data;
                break;
            end
        end
    endtask

    // Monitor/scoreboard: checks every cycle, then advances the model as the edge will.
    always @(negedge clk) begin
        int          sz;
        bit          exp_we;
        bit          h1, h2;
        logic [7:0]  d1, d2;
        wb_entry_t   e;
        if (reset) begin
            exp_q.delete();
        end else begin
            sz     = exp_q.size();
            exp_we = (sz != 0) && !stall;
            chk("pending",   32'(pending),   32'(sz));
            chk("empty",     32'(empty),     32'(sz == 0));
            chk("req_ready", 32'(req_ready), 32'(sz != DEPTH));
            chk("reg_Write", 32'(reg_Write), 32'(exp_we));
            if (reg_Write && sz != 0) begin
                chk("Write_Register", 32'(Write_Register), 32'(exp_q[0].addr));
                chk("Write_Data",     32'(Write_Data),     32'(exp_q[0].data));
            end
            lookup(Read_Register_1, h1, d1);
            lookup(Read_Register_2, h2, d2);
`ifdef WB_BYPASS_EN
            chk("Read_Data_1", 32'(Read_Data_1), 32'(h1 ? d1 : rf_Read_Data_1));
            chk("Read_Data_2", 32'(Read_Data_2), 32'(h2 ? d2 : rf_Read_Data_2));
            chk("hazard_1",    32'(hazard_1),    32'(0));
            chk("hazard_2",    32'(hazard_2),    32'(0));
`else
            chk("Read_Data_1", 32'(Read_Data_1), 32'(rf_Read_Data_1));
            chk("Read_Data_2", 32'(Read_Data_2), 32'(rf_Read_Data_2));
            chk("hazard_1",    32'(hazard_1),    32'(h1));
            chk("hazard_2",    32'(hazard_2),    32'(h2));
`endif
            if (exp_we) begin
                void'(exp_q.pop_front());
            end
            if (req_valid && sz != DEPTH) begin
                e.addr = req_addr;
                e.data = req_data;
                exp_q.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a request until it is accepted, with a bounded wait.
    task automatic send(input logic [2:0] a, input logic [7:0] d);
        int waited = 0;
        bit done   = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        while (!done) begin
            @(negedge clk);
            if (req_ready) done = 1;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout: got no accept for addr %0d expected accept within 200 cycles", a);
                    done = 1;
                end
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(2);

        // Single write with no stall
        send(3'd3, 8'h5A);
        idle(3);

        // Fill under stall, hold a fifth request, then release
        stall = 1'b1;
        for (int i = 0; i < 4; i++) send(3'(i), 8'h10 + 8'(i));
        fork
            send(3'd4, 8'h14);
            begin
                idle(5);
                stall = 1'b0;
            end
        join
        idle(6);

        // Duplicate address pending: youngest value wins
        stall           = 1'b1;
        Read_Register_1 = 3'd5;
        rf_Read_Data_1  = 8'h00;
        send(3'd5, 8'h11);
        send(3'd5, 8'h22);
        idle(3);
        stall = 1'b0;
        idle(4);

        // Full queue with stall low and a request held high
        stall = 1'b1;
        for (int i = 0; i < 4; i++) send(3'(7 - i), 8'hA0 + 8'(i));
        stall = 1'b0;
        send(3'd6, 8'hB6);
        idle(6);

        // Reset with entries pending
        stall = 1'b1;
        for (int i = 0; i < 3; i++) send(3'(i + 1), 8'hE0 + 8'(i));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        stall = 1'b0;
        idle(4);

        // Read of a register with nothing pending
        Read_Register_2 = 3'd7;
        rf_Read_Data_2  = 8'hC3;
        idle(2);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            req_valid       = ($urandom_range(0, 2) != 0);
            req_addr        = 3'($urandom);
            req_data        = 8'($urandom);
            stall           = ($urandom_range(0, 3) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            Read_Register_1 = 3'($urandom);
            Read_Register_2 = 3'($urandom);
            rf_Read_Data_1  = 8'($urandom);
            rf_Read_Data_2  = 8'($urandom);
            idle(1);
        end
        req_valid = 1'b0;
        stall     = 1'b0;
        reset     = 1'b0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_wb_queue
`default_nettype wire

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-back initiator for the 8-entry, 8-bit register file. It drives the file's write port and sits on its read path.
- Buffers write requests from the datapath in a small FIFO and drains them one per cycle onto the file's write port (reg_Write, Write_Register, Write_Data).
- Returns read data that reflects writes still waiting in the queue, so readers never see stale values.

Parameters:
- WORD_LENGTH, 8, data width; matches the register file.
- ADDR_BITS, 3, register index width; 8 registers.
- DEPTH, 4, queue entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  write request present.
- req_ready  output  1  queue can accept a request.
- req_addr  input  ADDR_BITS  destination register of the request.
- req_data  input  WORD_LENGTH  write data of the request.
- stall  input  1  holds the drain; no write-port activity while high.
- reg_Write  output  1  write enable to the register file.
- Write_Register  output  ADDR_BITS  register file write index.
- Write_Data  output  WORD_LENGTH  register file write data.
- Read_Register_1  input  ADDR_BITS  read index 1; also routed to the register file.
- Read_Register_2  input  ADDR_BITS  read index 2; also routed to the register file.
- rf_Read_Data_1  input  WORD_LENGTH  register file read port 1.
- rf_Read_Data_2  input  WORD_LENGTH  register file read port 2.
- Read_Data_1  output  WORD_LENGTH  coherent read data 1.
- Read_Data_2  output  WORD_LENGTH  coherent read data 2.
- hazard_1  output  1  read 1 targets a pending entry and the value is not forwarded.
- hazard_2  output  1  read 2 targets a pending entry and the value is not forwarded.
- pending  output  clog2(DEPTH)+1  current queue occupancy.
- empty  output  1  occupancy is 0.

Behaviour:
- Reset is synchronous and active-high, on clk. It clears the write pointer, read pointer and count; pending entries are discarded.
- After reset: req_ready=1, reg_Write=0, pending=0, empty=1, hazard_1/2=0.
- Entry storage contents are don't-care after reset and need no reset.
- Accept rule: a request is accepted on an edge where req_valid && req_ready. req_ready = (count != DEPTH).
- When full, requests are refused even if a pop happens in the same cycle. This avoids a combinational path from stall to req_ready.
- Drain rule: reg_Write = !empty && !stall. Write_Register and Write_Data always show the head entry; they show the last-written slot when the queue is empty.
- The head is popped on every edge where reg_Write=1.
- Latency: a request accepted at edge k into an empty queue is driven on the write port during cycle k+1. The register file captures it at edge k+1, provided stall is low.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Writes drain strictly in acceptance order. Duplicate addresses are allowed; the younger entry lands last.
- Read coherence: for each read port, search the valid queue entries youngest-first for an address match.
  - On a match the port is "pending"; otherwise Read_Data_n = rf_Read_Data_n.
  - The head being written this cycle still counts as pending. The file updates only at the edge.
  - A request presented in the same cycle but not yet accepted is never matched.
- Register 0 is an ordinary register; it gets no special casing.
- stall high with a full queue: req_ready=0, nothing moves, and outputs stay stable.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on a pending match, Read_Data_n = data of the youngest matching entry. hazard_1/2 are tied to 0.
- Undefined: Read_Data_n = rf_Read_Data_n always. hazard_n = 1 while read port n matches any pending entry; the consumer must stall.
- Both builds keep identical ports.

Decomposition:
- Shared package (reg_file_pkg):
  - constants: REG_WORD_LENGTH=8, REG_ADDR_BITS=3, REG_COUNT=8.
  - typedef: wb_entry_t, with addr[REG_ADDR_BITS] and data[REG_WORD_LENGTH].
- Sub-module: wb_match, instantiated once per read port. It is the combinational youngest-first address compare over the entry array plus valid mask, and outputs hit and hit_data.
- The FIFO storage and pointers stay inline.

Test Plan:
- After reset, push (addr 3, data 0x5A) with stall=0 → cycle k+1: reg_Write=1, Write_Register=3, Write_Data=0x5A; afterwards empty=1, pending=0.
- stall=1, push addr 0–3 with data 0x10–0x13 → req_ready falls to 0 after the 4th accept, a 5th request is held, and reg_Write stays 0. Release stall → four consecutive writes in order 0x10..0x13, then the held request is accepted.
- stall=1, queue (5,0x11) then (5,0x22), Read_Register_1=5, rf_Read_Data_1=0x00 → with bypass: Read_Data_1=0x22, hazard_1=0. Without bypass: Read_Data_1=0x00, hazard_1=1.
- Full queue with stall=0 and req_valid held high → req_ready=0 in the full cycle. After one pop, count=3 and req_ready=1; there is no simultaneous accept while full.
- Assert reset with 3 entries pending → next cycle pending=0, empty=1, reg_Write=0, req_ready=1; the discarded data never appears on the write port.
- Read_Register_2=7 with no pending entry for 7 and rf_Read_Data_2=0xC3 → Read_Data_2=0xC3, hazard_2=0.
